// File: rtl/text_buffer.sv
// text_buffer: ROWS x COLS character store with a rotating top-row pointer
// for hardware scroll and a sequential BLANK fill engine for clear/scroll.
// The scan-out read port is registered (one-cycle latency, read-first).
module text_buffer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned CHAR_W = 7,
    parameter logic [CHAR_W-1:0] BLANK = 7'h20,
    parameter int unsigned COL_W  = 7,
    parameter int unsigned ROW_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [COL_W-1:0]  i_wr_col,
    input  logic [ROW_W-1:0]  i_wr_row,
    input  logic [CHAR_W-1:0] i_wr_data,
    input  logic              i_clear_req,
    input  logic              i_scroll_req,
    output logic              o_busy,
    input  logic [COL_W-1:0]  i_rd_col,
    input  logic [ROW_W-1:0]  i_rd_row,
    output logic [CHAR_W-1:0] o_rd_data,
    output logic [ROW_W-1:0]  o_top_row
);

    localparam int unsigned DEPTH  = ROWS * COLS;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned SUM_W  = ROW_W + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] SCROLL = 2'd2;

    logic [CHAR_W-1:0] r_mem [DEPTH];

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_end;
    logic [ROW_W-1:0]  r_top_row;
    logic [CHAR_W-1:0] r_rd_data;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [CHAR_W-1:0] w_wdata;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [ADDR_W-1:0] w_cpu_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_row_base;
    logic [ROW_W-1:0]  w_top_next;

    // Logical (row, col) to physical address through the rotating top row.
    function automatic logic [ADDR_W-1:0] map_addr(input logic [ROW_W-1:0] top,
                                                   input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, top} + {1'b0, row};
        if (32'(sum) >= ROWS) begin
            sum = sum - SUM_W'(ROWS);
        end
        return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    // Address decode, range checks and write-port arbitration.
    always_comb begin
        w_wr_ok    = (32'(i_wr_col) < COLS) && (32'(i_wr_row) < ROWS);
        w_rd_ok    = (32'(i_rd_col) < COLS) && (32'(i_rd_row) < ROWS);
        w_cpu_addr = map_addr(r_top_row, i_wr_row, i_wr_col);
        w_rd_addr  = map_addr(r_top_row, i_rd_row, i_rd_col);
        w_row_base = ADDR_W'(r_top_row) * ADDR_W'(COLS);
        w_top_next = (32'(r_top_row) == ROWS - 1) ? '0 : r_top_row + 1'b1;
        // The fill owns the port while busy; CPU writes are only taken in IDLE.
        if (r_state != IDLE) begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
            w_wdata = BLANK;
        end else begin
            w_we    = i_wr_en && w_wr_ok;
            w_waddr = w_cpu_addr;
            w_wdata = i_wr_data;
        end
    end

    // Character RAM write port (contents are not reset; the fill clears them).
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Control FSM, fill pointer, top-row pointer and registered read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= CLEAR;
            r_ptr     <= '0;
            r_end     <= ADDR_W'(DEPTH - 1);
            r_top_row <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_ok ? r_mem[w_rd_addr] : BLANK;
            case (r_state)
                IDLE: begin
                    if (i_clear_req) begin
                        r_state   <= CLEAR;
                        r_ptr     <= '0;
                        r_end     <= ADDR_W'(DEPTH - 1);
                        r_top_row <= '0;
                    end else if (i_scroll_req) begin
                        r_state   <= SCROLL;
                        r_ptr     <= w_row_base;
                        r_end     <= w_row_base + ADDR_W'(COLS - 1);
                        r_top_row <= w_top_next;
                    end
                end
                CLEAR, SCROLL: begin
                    if (r_ptr == r_end) begin
                        r_state <= IDLE;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy    = (r_state != IDLE);
    assign o_rd_data = r_rd_data;
    assign o_top_row = r_top_row;

endmodule
